// File: rtl/dither_pkg.sv
// dither_pkg: shared widths, FSM state encoding and the offset clamp used by
// the dither_lockin servo block and its saturating adder.
package dither_pkg;

    localparam int N_B         = 16;
    localparam int SIGNAL_SIZE = 25;
    localparam int N_DIV       = 16;
    localparam int N_ACC       = N_B + N_DIV + 8 + 1;
    // Width of the integrator increment (shifted accumulator minus leak term).
    localparam int B_W         = N_ACC + 1;
    // Width of the pre-clamp sum; wide enough that no increment can wrap.
    localparam int SUM_W       = N_ACC + 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        UPDATE = 2'd2
    } state_t;

    localparam logic signed [SUM_W-1:0] OFFSET_MAX = SUM_W'((2 ** (SIGNAL_SIZE - 1)) - 1);
    localparam logic signed [SUM_W-1:0] OFFSET_MIN = -OFFSET_MAX;

    // Symmetric clamp of a wide sum into the offset range.
    function automatic logic signed [SIGNAL_SIZE-1:0] clamp(input logic signed [SUM_W-1:0] x);
        logic signed [SUM_W-1:0] y;
        if (x > OFFSET_MAX) begin
            y = OFFSET_MAX;
        end else if (x < OFFSET_MIN) begin
            y = OFFSET_MIN;
        end else begin
            y = x;
        end
        return SIGNAL_SIZE'(y);
    endfunction

    // True when clamp() would have to limit the value.
    function automatic logic out_of_range(input logic signed [SUM_W-1:0] x);
        return (x > OFFSET_MAX) || (x < OFFSET_MIN);
    endfunction

endpackage

// File: rtl/dither_sat_add.sv
// dither_sat_add: registered saturating adder that holds the integrated
// offset. On en it stores clamp(a + b) and records whether clamping occurred;
// otherwise both the sum and the sat flag hold their previous values.
module dither_sat_add
    import dither_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic signed [SIGNAL_SIZE-1:0] a,
    input  logic signed [B_W-1:0]         b,
    output logic signed [SIGNAL_SIZE-1:0] sum,
    output logic                          sat
);

    logic signed [SUM_W-1:0]       wide_sum;
    logic signed [SIGNAL_SIZE-1:0] sum_d, sum_q;
    logic                          sat_d, sat_q;

    // Sign-extend both operands, add at full width, then clamp when enabled.
    always_comb begin
        wide_sum = SUM_W'(a) + SUM_W'(b);
        sum_d    = sum_q;
        sat_d    = sat_q;
        if (en) begin
            sum_d = clamp(wide_sum);
            sat_d = out_of_range(wide_sum);
        end
    end

    // Offset and sat registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= '0;
            sat_q <= 1'b0;
        end else begin
            sum_q <= sum_d;
            sat_q <= sat_d;
        end
    end

    assign sum = sum_q;
    assign sat = sat_q;

endmodule

// File: rtl/dither_lockin.sv
// dither_lockin: square-wave dither generator with synchronous lock-in
// demodulation, settle blanking, whole-period averaging and a saturating
// integrator producing the servo offset.
// Optional feature macro: DITHER_LEAK_EN (leaky integrator, bleeds offset by
// offset>>>LEAK_SH at every non-hold update).
module dither_lockin
    import dither_pkg::*;
#(
    parameter int LEAK_SH = 12
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic signed [N_B-1:0]         e_in,
    input  logic                          DITHon,
    input  logic        [N_DIV-1:0]       half_period,
    input  logic        [N_DIV-1:0]       n_settle,
    input  logic        [7:0]             n_avg,
    input  logic signed [N_B-1:0]         amp,
    input  logic        [4:0]             gain_sh,
    input  logic                          hold,
    output logic signed [N_B-1:0]         mod,
    output logic signed [SIGNAL_SIZE-1:0] offset,
    output logic                          update,
    output logic                          sat
);

`ifdef DITHER_LEAK_EN
    localparam logic LEAK_ON = 1'b1;
`else
    localparam logic LEAK_ON = 1'b0;
`endif

    state_t                  state_d, state_q;
    logic                    phase_d, phase_q;
    logic        [N_DIV-1:0] cnt_d, cnt_q;
    logic        [7:0]       per_d, per_q;
    logic signed [N_ACC-1:0] acc_d, acc_q;
    logic signed [N_B-1:0]   mod_d, mod_q;
    logic                    update_d, update_q;
    logic        [N_DIV-1:0] hp_d, hp_q;
    logic        [N_DIV-1:0] ns_d, ns_q;
    logic        [7:0]       navg_d, navg_q;
    logic signed [N_B-1:0]   amp_d, amp_q;
    logic        [4:0]       gsh_d, gsh_q;

    logic signed [N_ACC-1:0]       e_ext;
    logic signed [N_ACC-1:0]       sample;
    logic                          last_cnt;
    logic                          last_per;
    logic                          wr_en;
    logic signed [B_W-1:0]         shifted;
    logic signed [B_W-1:0]         leak;
    logic signed [B_W-1:0]         step_b;
    logic signed [SIGNAL_SIZE-1:0] offset_w;
    logic                          sat_w;

    // Demodulated sample for this cycle: signed by phase, zero while blanked.
    always_comb begin
        e_ext    = N_ACC'(e_in);
        sample   = '0;
        if (cnt_q >= ns_q) begin
            sample = phase_q ? -e_ext : e_ext;
        end
        last_cnt = (cnt_q == hp_q - N_DIV'(1));
        last_per = (per_q == navg_q - 8'd1);
    end

    // Integrator increment: scaled accumulator, minus the leak term when enabled.
    always_comb begin
        shifted = B_W'(acc_q >>> gsh_q);
        leak    = '0;
        if (LEAK_ON) begin
            leak = B_W'(offset_w >>> LEAK_SH);
        end
        step_b  = shifted - leak;
    end

    // Next-state logic: period sequencing, accumulation, setting latches, mod drive.
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        cnt_d    = cnt_q;
        per_d    = per_q;
        acc_d    = acc_q;
        mod_d    = mod_q;
        hp_d     = hp_q;
        ns_d     = ns_q;
        navg_d   = navg_q;
        amp_d    = amp_q;
        gsh_d    = gsh_q;
        update_d = 1'b0;
        wr_en    = 1'b0;

        case (state_q)
            IDLE: begin
                acc_d = '0;
                mod_d = '0;
                if (DITHon) begin
                    hp_d    = (half_period < N_DIV'(2)) ? N_DIV'(2) : half_period;
                    ns_d    = n_settle;
                    navg_d  = (n_avg == 8'd0) ? 8'd1 : n_avg;
                    amp_d   = amp;
                    gsh_d   = gain_sh;
                    state_d = RUN;
                    phase_d = 1'b0;
                    cnt_d   = '0;
                    per_d   = '0;
                    mod_d   = amp;
                end
            end
            RUN, UPDATE: begin
                if (state_q == UPDATE) begin
                    acc_d    = sample;
                    update_d = 1'b1;
                    wr_en    = !hold;
                    hp_d     = (half_period < N_DIV'(2)) ? N_DIV'(2) : half_period;
                    ns_d     = n_settle;
                    navg_d   = (n_avg == 8'd0) ? 8'd1 : n_avg;
                    amp_d    = amp;
                    gsh_d    = gain_sh;
                end else begin
                    acc_d = acc_q + sample;
                end
                state_d = RUN;
                if (last_cnt) begin
                    cnt_d   = '0;
                    phase_d = ~phase_q;
                    if (phase_q) begin
                        if (last_per) begin
                            state_d = UPDATE;
                            per_d   = '0;
                        end else begin
                            per_d = per_q + 8'd1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + N_DIV'(1);
                end
                mod_d = phase_d ? -amp_d : amp_d;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (!DITHon) begin
            state_d  = IDLE;
            phase_d  = 1'b0;
            cnt_d    = '0;
            per_d    = '0;
            acc_d    = '0;
            mod_d    = '0;
            update_d = 1'b0;
            wr_en    = 1'b0;
        end
    end

    // State, counters, accumulator and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            phase_q  <= 1'b0;
            cnt_q    <= '0;
            per_q    <= '0;
            acc_q    <= '0;
            mod_q    <= '0;
            update_q <= 1'b0;
            hp_q     <= '0;
            ns_q     <= '0;
            navg_q   <= '0;
            amp_q    <= '0;
            gsh_q    <= '0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            cnt_q    <= cnt_d;
            per_q    <= per_d;
            acc_q    <= acc_d;
            mod_q    <= mod_d;
            update_q <= update_d;
            hp_q     <= hp_d;
            ns_q     <= ns_d;
            navg_q   <= navg_d;
            amp_q    <= amp_d;
            gsh_q    <= gsh_d;
        end
    end

    dither_sat_add u_integrator (
        .clk (clk),
        .rst (rst),
        .en  (wr_en),
        .a   (offset_w),
        .b   (step_b),
        .sum (offset_w),
        .sat (sat_w)
    );

    assign mod    = mod_q;
    assign offset = offset_w;
    assign update = update_q;
    assign sat    = sat_w;

endmodule

// File: tb/tb_dither_lockin.sv
// tb_dither_lockin: self-checking bench for dither_lockin. A time-indexed
// reference model predicts mod, update, offset and sat from the period
// arithmetic of the dither scheme.
module tb_dither_lockin;

`ifdef DITHER_LEAK_EN
    localparam int LSH = 2;
`else
    localparam int LSH = 12;
`endif
    localparam longint OMAX = (64'sd1 <<< 24) - 1;

    logic               clk = 1'b0;
    logic               rst;
    logic signed [15:0] e_in;
    logic               DITHon;
    logic        [15:0] half_period;
    logic        [15:0] n_settle;
    logic        [7:0]  n_avg;
    logic signed [15:0] amp;
    logic        [4:0]  gain_sh;
    logic               hold;
    logic signed [15:0] mod;
    logic signed [24:0] offset;
    logic               update;
    logic               sat;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    int                 m_hp, m_ns, m_navg, m_P, m_L, m_amp, m_gsh, m_t, m_e;
    logic               m_hold;
    longint             m_acc, m_off;
    logic               m_sat, m_upd;
    logic signed [15:0] exp_mod;

    dither_lockin #(.LEAK_SH(LSH)) dut (
        .clk         (clk),
        .rst         (rst),
        .e_in        (e_in),
        .DITHon      (DITHon),
        .half_period (half_period),
        .n_settle    (n_settle),
        .n_avg       (n_avg),
        .amp         (amp),
        .gain_sh     (gain_sh),
        .hold        (hold),
        .mod         (mod),
        .offset      (offset),
        .update      (update),
        .sat         (sat)
    );

    always #5 clk = ~clk;

    // Contribution of cycle t with input e: blanked within n_settle of each edge,
    // positive in the first half of a period, negative in the second.
    function automatic longint contrib(input int t, input int e);
        int k;
        k = t % m_P;
        if ((k % m_hp) < m_ns) return 0;
        return (k < m_hp) ? longint'(e) : -longint'(e);
    endfunction

    // Integrator step at the end of an averaging block.
    task automatic model_update();
        longint s;
        if (!m_hold) begin
            s = m_off + (m_acc >>> m_gsh);
`ifdef DITHER_LEAK_EN
            s = s - (m_off >>> LSH);
`endif
            m_sat = (s > OMAX) || (s < -OMAX);
            if (s > OMAX) s = OMAX;
            if (s < -OMAX) s = -OMAX;
            m_off = s;
        end
    endtask

    // Start a fresh dither run from IDLE with the given settings.
    task automatic begin_run(input int hp, input int ns, input int navg, input int a,
                             input int gsh, input logic h);
        DITHon = 1'b0;
        @(posedge clk);
        #1;
        half_period = 16'(hp);
        n_settle    = 16'(ns);
        n_avg       = 8'(navg);
        amp         = 16'(a);
        gain_sh     = 5'(gsh);
        hold        = h;
        DITHon      = 1'b1;
        m_hp   = (hp < 2) ? 2 : hp;
        m_ns   = ns;
        m_navg = (navg == 0) ? 1 : navg;
        m_P    = 2 * m_hp;
        m_L    = m_navg * m_P;
        m_amp  = a;
        m_gsh  = gsh;
        m_hold = h;
        m_t    = -1;
        m_acc  = 0;
        m_upd  = 1'b0;
    endtask

    // Advance one clock: fold the closed cycle into the model, then drive e_in
    // for the new cycle (mode 0 random, 1 phase-synchronous +/-val, 2 constant).
    task automatic applyStimulus(input int mode, input int val);
        int e;
        @(posedge clk);
        m_upd = 1'b0;
        if (m_t >= 0) begin
            if (m_t > 0 && (m_t % m_L) == 0) begin
                model_update();
                m_upd = 1'b1;
                m_acc = contrib(m_t, m_e);
            end else begin
                m_acc = m_acc + contrib(m_t, m_e);
            end
        end
        m_t = m_t + 1;
        #1;
        case (mode)
            0:       e = int'($urandom_range(0, 4000)) - 2000;
            1:       e = ((m_t % m_P) < m_hp) ? val : -val;
            default: e = val;
        endcase
        e_in    = 16'(e);
        m_e     = e;
        exp_mod = 16'(((m_t % m_P) < m_hp) ? m_amp : -m_amp);
    endtask

    task automatic test_reset();
        rst = 1'b1; DITHon = 1'b0; hold = 1'b0; e_in = '0;
        half_period = '0; n_settle = '0; n_avg = '0; amp = '0; gain_sh = '0;
        m_off = 0; m_sat = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (mod !== 16'sd0 || offset !== 25'sd0 || update !== 1'b0 || sat !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset: mod=%0d offset=%0d update=%b sat=%b, required all 0", mod, offset, update, sat);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (mod !== 16'sd0 || update !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL idle: mod=%0d update=%b, required 0/0", mod, update);
        end
    endtask

    task automatic test_mod_pattern();
        begin_run(4, 0, 1, 100, 0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            applyStimulus(2, 0);
            n_checks++;
            if (mod !== exp_mod || update !== m_upd || offset !== 25'(m_off)) begin
                n_fail++;
                $display("[TB] FAIL mod_pattern t=%0d: mod=%0d/%0d update=%b/%b offset=%0d/%0d (actual/required)",
                         m_t, mod, exp_mod, update, m_upd, offset, m_off);
            end
        end
    endtask

    task automatic test_demod();
        begin_run(4, 0, 1, 100, 0, 1'b0);
        for (int i = 0; i < 42; i++) begin
            applyStimulus(1, 10);
            n_checks++;
            if (mod !== exp_mod || update !== m_upd || offset !== 25'(m_off)) begin
                n_fail++;
                $display("[TB] FAIL demod t=%0d: mod=%0d/%0d update=%b/%b offset=%0d/%0d (actual/required)",
                         m_t, mod, exp_mod, update, m_upd, offset, m_off);
            end
            if (m_upd) begin
                n_checks++;
                if (sat !== m_sat) begin
                    n_fail++;
                    $display("[TB] FAIL demod_sat t=%0d: sat=%b required %b", m_t, sat, m_sat);
                end
            end
        end
    endtask

    task automatic test_settle();
        for (int pass = 0; pass < 2; pass++) begin
            begin_run(4, (pass == 0) ? 2 : 5, 1, 100, 0, 1'b0);
            for (int i = 0; i < 42; i++) begin
                applyStimulus(1, 10);
                n_checks++;
                if (mod !== exp_mod || update !== m_upd || offset !== 25'(m_off)) begin
                    n_fail++;
                    $display("[TB] FAIL settle ns=%0d t=%0d: mod=%0d/%0d update=%b/%b offset=%0d/%0d (actual/required)",
                             m_ns, m_t, mod, exp_mod, update, m_upd, offset, m_off);
                end
            end
        end
    endtask

    task automatic test_hold();
        begin_run(4, 0, 1, 100, 0, 1'b1);
        for (int i = 0; i < 34; i++) begin
            applyStimulus(1, 33);
            n_checks++;
            if (mod !== exp_mod || update !== m_upd || offset !== 25'(m_off)) begin
                n_fail++;
                $display("[TB] FAIL hold t=%0d: mod=%0d/%0d update=%b/%b offset=%0d/%0d (actual/required)",
                         m_t, mod, exp_mod, update, m_upd, offset, m_off);
            end
        end
    endtask

    task automatic test_saturation();
        begin_run(300, 0, 1, 1234, 0, 1'b0);
        for (int i = 0; i < 1802; i++) begin
            applyStimulus(1, (m_t + 1 < 1200) ? 30000 : -30000);
            n_checks++;
            if (mod !== exp_mod || update !== m_upd || offset !== 25'(m_off)) begin
                n_fail++;
                $display("[TB] FAIL saturation t=%0d: mod=%0d/%0d update=%b/%b offset=%0d/%0d (actual/required)",
                         m_t, mod, exp_mod, update, m_upd, offset, m_off);
            end
            if (m_upd) begin
                n_checks++;
                if (sat !== m_sat) begin
                    n_fail++;
                    $display("[TB] FAIL saturation_sat t=%0d: sat=%b required %b", m_t, sat, m_sat);
                end
            end
        end
    endtask

    task automatic test_dithon_drop();
        begin_run(4, 0, 1, 77, 0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 20);
        end
        DITHon = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (mod !== 16'sd0) begin
            n_fail++;
            $display("[TB] FAIL drop_mod: mod=%0d required 0", mod);
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (mod !== 16'sd0 || update !== 1'b0 || offset !== 25'(m_off)) begin
                n_fail++;
                $display("[TB] FAIL drop_hold: mod=%0d/0 update=%b/0 offset=%0d/%0d (actual/required)",
                         mod, update, offset, m_off);
            end
        end
    endtask

    task automatic test_random();
        for (int cfg = 0; cfg < 3; cfg++) begin
            begin_run(int'($urandom_range(0, 6)), int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 40000)) - 20000, int'($urandom_range(0, 4)),
                      logic'($urandom_range(0, 1)));
            for (int i = 0; i < 3 * m_L + 2; i++) begin
                applyStimulus(0, 0);
                n_checks++;
                if (mod !== exp_mod || update !== m_upd || offset !== 25'(m_off)) begin
                    n_fail++;
                    $display("[TB] FAIL random cfg=%0d t=%0d: mod=%0d/%0d update=%b/%b offset=%0d/%0d (actual/required)",
                             cfg, m_t, mod, exp_mod, update, m_upd, offset, m_off);
                end
                if (m_upd) begin
                    n_checks++;
                    if (sat !== m_sat) begin
                        n_fail++;
                        $display("[TB] FAIL random_sat cfg=%0d t=%0d: sat=%b required %b", cfg, m_t, sat, m_sat);
                    end
                end
            end
        end
    endtask

    task automatic test_async_reset();
        begin_run(4, 0, 1, 55, 0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1, 25);
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (mod !== 16'sd0 || offset !== 25'sd0 || update !== 1'b0 || sat !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL async_reset: mod=%0d offset=%0d update=%b sat=%b, required all 0", mod, offset, update, sat);
        end
        m_off  = 0;
        m_sat  = 1'b0;
        DITHon = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

`ifdef DITHER_LEAK_EN
    task automatic test_leak();
        longint want [4] = '{400, 300, 225, 169};
        int     n_upd = 0;
        begin_run(4, 0, 1, 100, 0, 1'b0);
        for (int i = 0; i < 34; i++) begin
            applyStimulus((m_t + 1 < 8) ? 1 : 2, (m_t + 1 < 8) ? 50 : 0);
            n_checks++;
            if (mod !== exp_mod || update !== m_upd || offset !== 25'(m_off)) begin
                n_fail++;
                $display("[TB] FAIL leak t=%0d: mod=%0d/%0d update=%b/%b offset=%0d/%0d (actual/required)",
                         m_t, mod, exp_mod, update, m_upd, offset, m_off);
            end
            if (m_upd && n_upd < 4) begin
                n_checks++;
                if (offset !== 25'(want[n_upd])) begin
                    n_fail++;
                    $display("[TB] FAIL leak_step%0d: offset=%0d required %0d", n_upd, offset, want[n_upd]);
                end
                n_upd++;
            end
        end
    endtask
`endif

    // Run every scenario in sequence and report.
    initial begin
        test_reset();
        test_mod_pattern();
        test_demod();
        test_settle();
        test_hold();
        test_saturation();
        test_dithon_drop();
        test_random();
        test_async_reset();
`ifdef DITHER_LEAK_EN
        test_leak();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
